dm_write_arbiter: RTL and testbench

- Sits between the four processor cores and the shared data memory write port.
- Buffers each core's write request (dm_en, ar_out, bus_out) in a per-core FIFO.
- Drains the FIFOs one write per cycle to a single memory write port, using round-robin arbitration.
- Removes same-cycle write collisions and gives deterministic write ordering; flags any request lost to back-pressure.

---
 rtl/dm_write_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_dm_write_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dm_write_arbiter.sv
// dm_write_arbiter
//
// Funnels the data-memory write requests of four cores into one memory write
// port. Every core has a small FIFO holding {addr, data}. A round-robin
// arbiter pops at most one head per cycle and registers it onto the mem_*
// outputs, so simultaneous writes are serialised in a fixed order.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   req_valid  per-core write request (core dm_en)
//   req_addr   core i address at [i*ADDR_W +: ADDR_W]
//   req_data   core i data at [i*DATA_W +: DATA_W]
//   req_ready  per-core FIFO can accept this cycle
//   mem_we     registered write strobe to data memory
//   mem_addr   registered write address
//   mem_data   registered write data
//   mem_core   index of the core whose write is on mem_*
//   overflow   sticky per-core flag: request dropped because the FIFO was full
//   idle       registered: all FIFOs empty and no write in flight
module dm_write_arbiter #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 17,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            req_valid,
    input  logic [4*ADDR_W-1:0]   req_addr,
    input  logic [4*DATA_W-1:0]   req_data,
    output logic [3:0]            req_ready,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_data,
    output logic [1:0]            mem_core,
    output logic [3:0]            overflow,
    output logic                  idle
);

    localparam int NCORE   = 4;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_W + DATA_W;

    // Per-core FIFO state
    logic [ENTRY_W-1:0] fifo_mem [NCORE][DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q [NCORE];
    logic [PTR_W-1:0]   rd_ptr_q [NCORE];
    logic [CNT_W-1:0]   count_q  [NCORE];
    logic [CNT_W-1:0]   count_d  [NCORE];
    logic [ENTRY_W-1:0] push_entry [NCORE];

    logic [NCORE-1:0]   push;
    logic [NCORE-1:0]   pop;
    logic [NCORE-1:0]   drop;

    // Arbiter state
    logic [1:0]         rr_ptr_q;
    logic               gnt_valid;
    logic [1:0]         gnt_idx;
    logic [1:0]         cand;
    logic [ENTRY_W-1:0] head_entry;

    // Registered outputs
    logic               mem_we_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [DATA_W-1:0]  mem_data_q;
    logic [1:0]         mem_core_q;
    logic [3:0]         overflow_q;
    logic               idle_q;
    logic               idle_d;

    // ------------------------------------------------------------------
    // Request side: readiness depends only on the current count, so a full
    // FIFO refuses a push even in a cycle where it is also being popped.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NCORE; i++) begin
            req_ready[i]  = rst_n && (count_q[i] < CNT_W'(DEPTH));
            push[i]       = req_valid[i] && req_ready[i];
            drop[i]       = req_valid[i] && !req_ready[i];
            push_entry[i] = {req_addr[i*ADDR_W +: ADDR_W], req_data[i*DATA_W +: DATA_W]};
        end
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter: scan starting just after the last granted core,
    // ending with the last granted core itself.
    // ------------------------------------------------------------------
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = 2'd0;
        cand      = 2'd0;
        for (int k = 1; k <= NCORE; k++) begin
            cand = rr_ptr_q + 2'(k);
            if (!gnt_valid && (count_q[cand] != '0)) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NCORE; i++) begin
            pop[i] = gnt_valid && (gnt_idx == 2'(i));
        end
    end

    assign head_entry = fifo_mem[gnt_idx][rd_ptr_q[gnt_idx]];

    // ------------------------------------------------------------------
    // Next-state counts and idle. Idle looks at the post-edge state: every
    // FIFO empty and no write being launched on this edge.
    // ------------------------------------------------------------------
    always_comb begin
        idle_d = !gnt_valid;
        for (int i = 0; i < NCORE; i++) begin
            unique case ({push[i], pop[i]})
                2'b10:   count_d[i] = count_q[i] + CNT_W'(1);
                2'b01:   count_d[i] = count_q[i] - CNT_W'(1);
                default: count_d[i] = count_q[i];
            endcase
            if (count_d[i] != '0) begin
                idle_d = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage. Not reset: entries are only visible through the
    // pointers/counts, which are.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCORE; i++) begin
            if (push[i]) begin
                fifo_mem[i][wr_ptr_q[i]] <= push_entry[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Control state and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NCORE; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            // Pointing at core 3 makes core 0 the first in line.
            rr_ptr_q   <= 2'd3;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_core_q <= 2'd0;
            overflow_q <= 4'b0000;
            idle_q     <= 1'b1;
        end else begin
            for (int i = 0; i < NCORE; i++) begin
                if (push[i]) begin
                    wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
                end
                count_q[i] <= count_d[i];
            end
            overflow_q <= overflow_q | drop;
            mem_we_q   <= gnt_valid;
            // Address/data/core hold their last values when nothing is granted.
            if (gnt_valid) begin
                rr_ptr_q   <= gnt_idx;
                mem_addr_q <= head_entry[ENTRY_W-1 -: ADDR_W];
                mem_data_q <= head_entry[DATA_W-1:0];
                mem_core_q <= gnt_idx;
            end
            idle_q <= idle_d;
        end
    end

    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign mem_core = mem_core_q;
    assign overflow = overflow_q;
    assign idle     = idle_q;

endmodule

// File: tb/tb_dm_write_arbiter.sv
// Directed testbench for dm_write_arbiter. Inputs change and outputs are
// sampled 1 ns after each rising clock edge.
module tb_dm_write_arbiter;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 17;
    localparam int unsigned DEPTH  = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [3:0]          req_valid;
    logic [4*ADDR_W-1:0] req_addr;
    logic [4*DATA_W-1:0] req_data;
    logic [3:0]          req_ready;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_data;
    logic [1:0]          mem_core;
    logic [3:0]          overflow;
    logic                idle;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dm_write_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_core  (mem_core),
        .overflow  (overflow),
        .idle      (idle)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
    endtask

    task automatic set_req(input int c, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_valid[c]                 = 1'b1;
        req_addr[c*ADDR_W +: ADDR_W] = a;
        req_data[c*DATA_W +: DATA_W] = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_req();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic chk_wr(input string tag, input int c, input int a, input int d);
        chk({tag, "_we"},   32'(mem_we),   32'd1);
        chk({tag, "_core"}, 32'(mem_core), 32'(c));
        chk({tag, "_addr"}, 32'(mem_addr), 32'(a));
        chk({tag, "_data"}, 32'(mem_data), 32'(d));
    endtask

    // Overflow scenario: expected writes on edges 2..15 (core, sequence number).
    int exp_c [14] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 1, 1, 1};
    int exp_k [14] = '{0, 0, 1, 2, 4, 1, 5, 6, 8, 2, 9, 3, 4, 7};

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        // ---------------- reset state ----------------
        rst_n = 1'b0;
        clear_req();
        tick();
        tick();
        chk("rst_we",       32'(mem_we),    32'd0);
        chk("rst_addr",     32'(mem_addr),  32'd0);
        chk("rst_data",     32'(mem_data),  32'd0);
        chk("rst_core",     32'(mem_core),  32'd0);
        chk("rst_overflow", 32'(overflow),  32'd0);
        chk("rst_idle",     32'(idle),      32'd1);
        chk("rst_ready",    32'(req_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready",    32'(req_ready), 32'hf);

        // ---------------- single write from core 2 ----------------
        set_req(2, 12'h005, 17'h00abc);
        tick();
        clear_req();
        chk("single_acc_we",   32'(mem_we), 32'd0);
        chk("single_acc_idle", 32'(idle),   32'd0);
        tick();
        chk_wr("single", 2, 'h005, 'h00abc);
        chk("single_busy_idle", 32'(idle), 32'd0);
        tick();
        chk("single_done_we",   32'(mem_we),   32'd0);
        chk("single_done_idle", 32'(idle),     32'd1);
        chk("single_hold_addr", 32'(mem_addr), 32'h005);

        // ---------------- all four cores at once after reset ----------------
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, ADDR_W'(12'h010 + i), DATA_W'(i));
        #1;
        chk("all4_ready_pre", 32'(req_ready), 32'hf);
        tick();
        clear_req();
        chk("all4_ready_post", 32'(req_ready), 32'hf);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_wr($sformatf("all4_%0d", i), i, 'h010 + i, i);
        end
        tick();
        chk("all4_done_we",   32'(mem_we), 32'd0);
        chk("all4_done_idle", 32'(idle),   32'd1);

        // ---------------- fairness: last grant core 1, then 0 and 3 ----------------
        set_req(1, 12'h031, 17'h00011);
        tick();
        clear_req();
        tick();
        chk_wr("fair_c1", 1, 'h031, 'h11);
        set_req(0, 12'h040, 17'h00100);
        set_req(3, 12'h043, 17'h00103);
        tick();
        clear_req();
        tick();
        chk_wr("fair_first", 3, 'h043, 'h103);
        tick();
        chk_wr("fair_second", 0, 'h040, 'h100);
        tick();
        chk("fair_idle", 32'(idle), 32'd1);

        // ---------------- overflow on core 1 ----------------
        // Core 1 every cycle; core 0 at k=0,4,8; core 2 at k=1,5,9; core 3 at k=2,6.
        do_reset();
        for (int e = 1; e <= 15; e++) begin
            clear_req();
            if (e <= 10) begin
                int k;
                k = e - 1;
                set_req(1, ADDR_W'(12'h210 + k), DATA_W'(17'h00100 + k));
                if (k % 4 == 0) set_req(0, ADDR_W'(12'h200 + k), DATA_W'(k));
                if (k % 4 == 1) set_req(2, ADDR_W'(12'h220 + k), DATA_W'(17'h00200 + k));
                if (k == 2 || k == 6) set_req(3, ADDR_W'(12'h230 + k), DATA_W'(17'h00300 + k));
            end
            tick();
            if (e == 1) begin
                chk("ovf_e1_we", 32'(mem_we), 32'd0);
            end else begin
                chk_wr($sformatf("ovf_e%0d", e), exp_c[e-2],
                       'h200 + 16 * exp_c[e-2] + exp_k[e-2],
                       256 * exp_c[e-2] + exp_k[e-2]);
            end
            if (e == 5) chk("ovf_ready_full", 32'(req_ready), 32'b1101);
            if (e == 6) chk("ovf_flag_set",   32'(overflow),  32'b0010);
            if (e == 7) chk("ovf_ready_back", 32'(req_ready), 32'hf);
        end
        clear_req();
        tick();
        chk("ovf_end_we",       32'(mem_we),   32'd0);
        chk("ovf_end_idle",     32'(idle),     32'd1);
        chk("ovf_end_overflow", 32'(overflow), 32'b0010);

        // ---------------- reset mid-drain ----------------
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, ADDR_W'(12'h300 + i), DATA_W'(i));
        tick();
        clear_req();
        set_req(0, 12'h301, 17'h00011);
        tick();
        chk_wr("mid_w0", 0, 'h300, 0);
        clear_req();
        set_req(0, 12'h302, 17'h00012);
        tick();
        chk_wr("mid_w1", 1, 'h301, 1);
        clear_req();
        set_req(0, 12'h303, 17'h00013);
        tick();
        chk_wr("mid_w2", 2, 'h302, 2);
        // Core 0 now holds three entries, core 3 one.
        rst_n = 1'b0;
        clear_req();
        tick();
        chk("mid_rst_we",    32'(mem_we),    32'd0);
        chk("mid_rst_idle",  32'(idle),      32'd1);
        chk("mid_rst_addr",  32'(mem_addr),  32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("mid_quiet_we_%0d", i),   32'(mem_we), 32'd0);
            chk($sformatf("mid_quiet_idle_%0d", i), 32'(idle),   32'd1);
        end

        // ---------------- same-address race, rr restarted at core 0 ----------------
        set_req(0, 12'h020, 17'h00001);
        set_req(3, 12'h020, 17'h00002);
        tick();
        clear_req();
        tick();
        chk_wr("race_first", 0, 'h020, 1);
        tick();
        chk_wr("race_second", 3, 'h020, 2);
        tick();
        chk("race_final_data", 32'(mem_data), 32'd2);
        chk("race_we",         32'(mem_we),   32'd0);
        chk("race_idle",       32'(idle),     32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
